// File: rtl/repeated_pattern_2d_pkg.sv
// Shared types and default sizing for the 2-D repeated-pattern mask generator.
package rp_pkg;

  localparam int MAX_PW_DEF    = 32;
  localparam int MAX_PH_DEF    = 32;
  localparam int IMG_W_MAX_DEF = 1920;
  localparam int IMG_H_MAX_DEF = 1080;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rp_state_e;

endpackage

// File: rtl/rp_pattern_store.sv
// Shadow/active pattern buffers with atomic commit; a commit during a frame is
// held pending and lands on the handshake of that frame's last beat.
module rp_pattern_store
  import rp_pkg::*;
#(
  parameter int MAX_PW = MAX_PW_DEF,
  parameter int MAX_PH = MAX_PH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en_i,
  input  logic [$clog2(MAX_PW+1)-1:0] pattern_w_i,
  input  logic [$clog2(MAX_PH+1)-1:0] pattern_h_i,
  input  logic [0:MAX_PW-1]           row_data_i,
  input  logic [$clog2(MAX_PH)-1:0]   row_idx_i,
  input  logic                        row_we_i,
  input  logic                        commit_i,
  input  logic                        run_i,
  input  logic                        eof_hs_i,
  input  logic [$clog2(MAX_PH)-1:0]   rd_py_i,
  input  logic [$clog2(MAX_PW)-1:0]   rd_px_i,
  output logic                        rd_bit_o,
  output logic [$clog2(MAX_PW+1)-1:0] pw_o,
  output logic [$clog2(MAX_PH+1)-1:0] ph_o,
  output logic                        committed_o,
  output logic                        commit_ok_o,
  output logic                        commit_bad_o
);

  localparam int PWW = $clog2(MAX_PW+1);
  localparam int PHW = $clog2(MAX_PH+1);
  localparam logic [PWW-1:0] PW_LIM = PWW'(MAX_PW);
  localparam logic [PHW-1:0] PH_LIM = PHW'(MAX_PH);

  logic [0:MAX_PW-1] shadow_q [MAX_PH];
  logic [0:MAX_PW-1] shadow_d [MAX_PH];
  logic [0:MAX_PW-1] active_q [MAX_PH];
  logic [0:MAX_PW-1] active_d [MAX_PH];
  logic [PWW-1:0]    pw_q, pw_d, pend_pw_q, pend_pw_d;
  logic [PHW-1:0]    ph_q, ph_d, pend_ph_q, pend_ph_d;
  logic              pending_q, pending_d;
  logic              committed_q, committed_d;
  logic              dims_ok;

  always_comb begin
    dims_ok = (pattern_w_i != '0) && (pattern_w_i <= PW_LIM) &&
              (pattern_h_i != '0) && (pattern_h_i <= PH_LIM);
    commit_ok_o  = clk_en_i & commit_i & dims_ok;
    commit_bad_o = clk_en_i & commit_i & ~dims_ok;

    shadow_d = shadow_q;
    if (clk_en_i && row_we_i && (int'(row_idx_i) < MAX_PH))
      shadow_d[row_idx_i] = row_data_i;

    active_d    = active_q;
    pw_d        = pw_q;
    ph_d        = ph_q;
    pend_pw_d   = pend_pw_q;
    pend_ph_d   = pend_ph_q;
    pending_d   = pending_q;
    committed_d = committed_q;
    // Copies use shadow_d so a row written in the same cycle is included.
    if (commit_ok_o && (!run_i || eof_hs_i)) begin
      active_d    = shadow_d;
      pw_d        = pattern_w_i;
      ph_d        = pattern_h_i;
      committed_d = 1'b1;
      pending_d   = 1'b0;
    end else if (commit_ok_o) begin
      pending_d = 1'b1;
      pend_pw_d = pattern_w_i;
      pend_ph_d = pattern_h_i;
    end else if (eof_hs_i && pending_q) begin
      active_d  = shadow_d;
      pw_d      = pend_pw_q;
      ph_d      = pend_ph_q;
      pending_d = 1'b0;
    end

    // Read the post-commit view so the first beat of a frame sees the new pattern.
    rd_bit_o = active_d[rd_py_i][rd_px_i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_PH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pw_q        <= '0;
      ph_q        <= '0;
      pend_pw_q   <= '0;
      pend_ph_q   <= '0;
      pending_q   <= 1'b0;
      committed_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pw_q        <= pw_d;
      ph_q        <= ph_d;
      pend_pw_q   <= pend_pw_d;
      pend_ph_q   <= pend_ph_d;
      pending_q   <= pending_d;
      committed_q <= committed_d;
    end
  end

  assign pw_o        = pw_q;
  assign ph_o        = ph_q;
  assign committed_o = committed_q;

endmodule

// File: rtl/repeated_pattern_2d.sv
// Tiles a committed W x H binary pattern across a frame and streams one mask
// bit per pixel in raster order.
module repeated_pattern_2d
  import rp_pkg::*;
#(
  parameter int MAX_PW    = MAX_PW_DEF,
  parameter int MAX_PH    = MAX_PH_DEF,
  parameter int IMG_W_MAX = IMG_W_MAX_DEF,
  parameter int IMG_H_MAX = IMG_H_MAX_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clk_en,
  input  logic [$clog2(MAX_PW+1)-1:0]    pattern_w,
  input  logic [$clog2(MAX_PH+1)-1:0]    pattern_h,
  input  logic [0:MAX_PW-1]              row_data,
  input  logic [$clog2(MAX_PH)-1:0]      row_idx,
  input  logic                           row_we,
  input  logic                           commit,
  input  logic [$clog2(IMG_W_MAX+1)-1:0] img_w,
  input  logic [$clog2(IMG_H_MAX+1)-1:0] img_h,
  input  logic                           frame_start,
  output logic                           rp_mask_bit,
  output logic                           rp_valid,
  input  logic                           rp_ready,
  output logic                           rp_eol,
  output logic                           rp_eof,
  output logic                           busy,
  output logic                           cfg_err,
  output logic                           dbg_state_o
);

  localparam int XW  = $clog2(IMG_W_MAX+1);
  localparam int YW  = $clog2(IMG_H_MAX+1);
  localparam int PXW = $clog2(MAX_PW);
  localparam int PYW = $clog2(MAX_PH);
  localparam int PWW = $clog2(MAX_PW+1);
  localparam int PHW = $clog2(MAX_PH+1);

  rp_state_e      state_q;
  logic [XW-1:0]  x_q, x_d, iw_q, iw_d;
  logic [YW-1:0]  y_q, y_d, ih_q, ih_d;
  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  logic           mask_q, valid_q, eol_q, eof_q, busy_q, err_q;
  logic           eol_d, eof_d;
  logic           hs, eof_hs, start_ok, start_bad, cfg_ok;
  logic           rd_bit, committed, commit_ok, commit_bad;
  logic [PWW-1:0] pw;
  logic [PHW-1:0] ph;

  rp_pattern_store #(
    .MAX_PW (MAX_PW),
    .MAX_PH (MAX_PH)
  ) u_store (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en_i     (clk_en),
    .pattern_w_i  (pattern_w),
    .pattern_h_i  (pattern_h),
    .row_data_i   (row_data),
    .row_idx_i    (row_idx),
    .row_we_i     (row_we),
    .commit_i     (commit),
    .run_i        (state_q == RUN),
    .eof_hs_i     (eof_hs),
    .rd_py_i      (py_d),
    .rd_px_i      (px_d),
    .rd_bit_o     (rd_bit),
    .pw_o         (pw),
    .ph_o         (ph),
    .committed_o  (committed),
    .commit_ok_o  (commit_ok),
    .commit_bad_o (commit_bad)
  );

  // A beat transfers on a rising edge where rp_valid, rp_ready and clk_en are all
  // high; until then rp_mask_bit/rp_eol/rp_eof hold, and rp_valid never drops
  // without a transfer.
  always_comb begin
    hs        = valid_q & rp_ready & clk_en;
    eof_hs    = hs & eof_q;
    cfg_ok    = committed && (img_w != '0) && (img_h != '0);
    start_ok  = clk_en & frame_start & (state_q == IDLE) & cfg_ok;
    start_bad = clk_en & frame_start & (state_q == IDLE) & ~cfg_ok;

    x_d  = x_q;
    y_d  = y_q;
    px_d = px_q;
    py_d = py_q;
    iw_d = iw_q;
    ih_d = ih_q;
    if (start_ok) begin
      iw_d = img_w;
      ih_d = img_h;
      x_d  = '0;
      y_d  = '0;
      px_d = '0;
      py_d = '0;
    end else if (hs && !eof_q) begin
      if (eol_q) begin
        x_d  = '0;
        px_d = '0;
        y_d  = y_q + YW'(1);
        py_d = (PHW'(py_q) == ph - PHW'(1)) ? '0 : py_q + PYW'(1);
      end else begin
        x_d  = x_q + XW'(1);
        px_d = (PWW'(px_q) == pw - PWW'(1)) ? '0 : px_q + PXW'(1);
      end
    end

    eol_d = (x_d == iw_d - XW'(1));
    eof_d = eol_d && (y_d == ih_d - YW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      iw_q    <= '0;
      ih_q    <= '0;
      mask_q  <= 1'b0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (clk_en) begin
      x_q  <= x_d;
      y_q  <= y_d;
      px_q <= px_d;
      py_q <= py_d;
      iw_q <= iw_d;
      ih_q <= ih_d;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= RUN;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            mask_q  <= rd_bit;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
          end
        end
        RUN: begin
          if (eof_hs) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            mask_q  <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
          end else if (hs) begin
            mask_q <= rd_bit;
            eol_q  <= eol_d;
            eof_q  <= eof_d;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (start_bad || commit_bad)
        err_q <= 1'b1;
      else if (start_ok || commit_ok)
        err_q <= 1'b0;
    end
  end

  assign rp_mask_bit = mask_q;
  assign rp_valid    = valid_q;
  assign rp_eol      = eol_q;
  assign rp_eof      = eof_q;
  assign busy        = busy_q;
  assign cfg_err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_repeated_pattern_2d.sv
// Directed bench for repeated_pattern_2d: a pixel-level model predicts every beat
// as pattern[y mod ph][x mod pw]; literal frames pin the model.
module tb_repeated_pattern_2d;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clk_en      = 1'b1;
  logic        rp_ready    = 1'b1;
  logic [5:0]  pattern_w   = '0;
  logic [5:0]  pattern_h   = '0;
  logic [0:31] row_data    = '0;
  logic [4:0]  row_idx     = '0;
  logic        row_we      = 1'b0;
  logic        commit      = 1'b0;
  logic [10:0] img_w       = '0;
  logic [10:0] img_h       = '0;
  logic        frame_start = 1'b0;
  logic        rp_mask_bit, rp_valid, rp_eol, rp_eof, busy, cfg_err, dbg_state;

  repeated_pattern_2d dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .pattern_w   (pattern_w),
    .pattern_h   (pattern_h),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .row_we      (row_we),
    .commit      (commit),
    .img_w       (img_w),
    .img_h       (img_h),
    .frame_start (frame_start),
    .rp_mask_bit (rp_mask_bit),
    .rp_valid    (rp_valid),
    .rp_ready    (rp_ready),
    .rp_eol      (rp_eol),
    .rp_eof      (rp_eof),
    .busy        (busy),
    .cfg_err     (cfg_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- model state ----------------
  int          tests = 0;
  int          fails = 0;
  int          mode  = 0;
  logic [2:0]  exp_q[$];
  logic        cap[$];
  logic [0:31] m_sh[32];
  logic [0:31] m_act[32];
  logic [0:31] m_pend_sh[32];
  int          m_pw, m_ph, m_pend_pw, m_pend_ph;
  bit          m_committed, m_pend, m_running, m_err, post_eof;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_sh[i]      = '0;
      m_act[i]     = '0;
      m_pend_sh[i] = '0;
    end
    m_pw = 0; m_ph = 0; m_pend_pw = 0; m_pend_ph = 0;
    m_committed = 0; m_pend = 0; m_running = 0; m_err = 0; post_eof = 0;
    exp_q.delete();
    cap.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_row(input int idx, input logic [0:31] data);
    row_idx  = 5'(idx);
    row_data = data;
    row_we   = 1'b1;
    m_sh[idx] = data;
    tick();
    row_we = 1'b0;
  endtask

  task automatic do_commit(input int w, input int h);
    pattern_w = 6'(w);
    pattern_h = 6'(h);
    commit    = 1'b1;
    tick();
    commit = 1'b0;
    if (w >= 1 && w <= 32 && h >= 1 && h <= 32) begin
      m_err = 0;
      if (m_running) begin
        m_pend = 1; m_pend_sh = m_sh; m_pend_pw = w; m_pend_ph = h;
      end else begin
        m_act = m_sh; m_pw = w; m_ph = h; m_committed = 1;
      end
    end else begin
      m_err = 1;
    end
    check("cfg_err_after_commit", 64'(cfg_err), 64'(m_err));
  endtask

  task automatic start_frame(input int w, input int h);
    bit ok;
    bit was_running;
    was_running = m_running;
    ok = !m_running && m_committed && w != 0 && h != 0;
    img_w = 11'(w);
    img_h = 11'(h);
    frame_start = 1'b1;
    if (ok) begin
      if (m_pend) begin
        m_act = m_pend_sh; m_pw = m_pend_pw; m_ph = m_pend_ph; m_pend = 0;
      end
      cap.delete();
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++)
          exp_q.push_back({x == w-1, (x == w-1) && (y == h-1), m_act[y % m_ph][x % m_pw]});
      m_running = 1;
      m_err = 0;
    end else if (!m_running) begin
      m_err = 1;
    end
    tick();
    frame_start = 1'b0;
    check("cfg_err_after_start", 64'(cfg_err), 64'(m_err));
    if (ok)
      check("busy_valid_rise", {62'd0, busy, rp_valid}, 64'd3);
    else if (!was_running)
      check("no_valid_after_reject", 64'(rp_valid), 64'd0);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (m_running && n < 3000) begin
      tick();
      n++;
    end
    if (m_running) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
      m_running = 0;
    end
  endtask

  function automatic logic [63:0] cap_vec(input int start, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = start; i < start + n; i++)
      v = {v[62:0], (i < cap.size()) ? cap[i] : 1'b0};
    return v;
  endfunction

  // Handshake partner: ready/enable pattern selected by mode.
  always @(posedge clk) begin
    #2;
    if (mode == 2) begin
      rp_ready = 1'($urandom_range(0, 1));
      clk_en   = ($urandom_range(0, 3) != 0);
    end else begin
      rp_ready = 1'b1;
      clk_en   = 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (post_eof) begin
      post_eof = 0;
      check("busy_fall_after_eof", {62'd0, busy, rp_valid}, 64'd0);
    end
    if (rp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got rp_valid=1 expected 0");
      end else begin
        check("beat", {60'd0, busy, rp_eol, rp_eof, rp_mask_bit}, {60'd0, 1'b1, exp_q[0]});
        if (rp_ready && clk_en) begin
          cap.push_back(rp_mask_bit);
          if (exp_q[0][1]) begin
            m_running = 0;
            post_eof  = 1;
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  logic [29:0] line1;
  logic [0:31] ones;

  initial begin
    line1 = 30'b111100110000111100001111111100;
    ones  = '1;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_outputs", {57'd0, rp_valid, rp_mask_bit, rp_eol, rp_eof, busy, cfg_err, dbg_state}, 64'd0);
    tick();

    // Single-row 24-wide pattern over a 30x2 frame
    write_row(0, {24'hF30F0F, 8'h00});
    do_commit(24, 1);
    start_frame(30, 2);
    wait_frame();
    check("c1_beats", 64'(cap.size()), 64'd60);
    check("c1_line0", cap_vec(0, 30), 64'(line1));
    check("c1_line1", cap_vec(30, 30), 64'(line1));

    // Back-to-back frame with random stalls and clock-enable gaps
    start_frame(30, 2);
    mode = 2;
    wait_frame();
    mode = 0;
    check("c3_stream", cap_vec(0, 60), {4'd0, line1, line1});

    // 2x2 checkerboard over 5x3
    write_row(0, {2'b10, 30'd0});
    write_row(1, {2'b01, 30'd0});
    do_commit(2, 2);
    start_frame(5, 3);
    wait_frame();
    check("c2_frame", cap_vec(0, 15), 64'b101010101010101);

    // Commit mid-frame lands only for the next frame; frame_start in RUN ignored
    start_frame(5, 3);
    repeat (3) tick();
    write_row(0, ones);
    start_frame(7, 7);
    do_commit(4, 1);
    wait_frame();
    check("c4_old_frame", cap_vec(0, 15), 64'b101010101010101);
    start_frame(6, 2);
    wait_frame();
    check("c4_new_frame", cap_vec(0, 12), 64'hFFF);

    // Rejected configurations
    do_commit(0, 1);
    start_frame(6, 2);
    wait_frame();
    check("c5_active_kept", cap_vec(0, 12), 64'hFFF);
    start_frame(0, 2);
    repeat (2) tick();
    check("c5_zero_w_no_valid", 64'(rp_valid), 64'd0);
    do_commit(2, 2);

    // Reset mid-frame clears everything, including the committed pattern
    start_frame(30, 2);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("c6_async_reset", {58'd0, rp_valid, rp_mask_bit, rp_eol, rp_eof, busy, cfg_err}, 64'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    start_frame(6, 2);
    repeat (3) tick();
    check("c6_no_valid_after_reset", 64'(rp_valid), 64'd0);

    repeat (3) tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
